// File: rtl/wb_ext_responder.sv
// Wishbone B3 slave with local word storage: wait states, classic and
// incrementing/wrapping bursts, err for out-of-window beats, rty on request.
module wb_ext_responder #(
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
   parameter int unsigned MEM_WORDS   = 1024,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic        wb_cab_i,
   input  logic [2:0]  wb_cti_i,
   input  logic [1:0]  wb_bte_i,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        wb_rty_o,
   output logic [31:0] wb_dat_o,
   input  logic        retry_req
);

   localparam int unsigned AW   = $clog2(MEM_WORDS);
   localparam logic [32:0] C_LO = {1'b0, ADDR_BASE};
   localparam logic [32:0] C_HI = C_LO + 33'(4 * MEM_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_TERM} state_t;

   state_t      r_state;
   logic [3:0]  r_wcnt;
   logic [32:0] r_adr;
   logic [1:0]  r_bte;
   logic        r_burst;
   logic        r_we;
   logic        r_retry;
   logic        r_ack;
   logic        r_err;
   logic        r_rty;
   logic [31:0] r_dat;
   logic [31:0] r_mem [MEM_WORDS];

   logic [32:0]   w_next;
   logic [32:0]   w_iss_adr;
   logic [31:0]   w_iss_off;
   logic [31:0]   w_cur_off;
   logic [AW-1:0] w_iss_idx;
   logic [AW-1:0] w_cur_idx;
   logic          w_iss_ok;
   logic          w_advance;
   logic          w_wen;
   logic          w_unused;

   // Address kept 33 bits wide so a linear burst stepping past 4 GiB cannot alias into the window.
   always_comb begin
      w_next = r_adr;
      case (r_bte)
         2'b00:   w_next      = r_adr + 33'd4;
         2'b01:   w_next[3:2] = r_adr[3:2] + 2'd1;
         2'b10:   w_next[4:2] = r_adr[4:2] + 3'd1;
         default: w_next[5:2] = r_adr[5:2] + 4'd1;
      endcase
   end

   assign w_advance = r_ack && r_burst && (wb_cti_i != 3'b111);
   assign w_iss_adr = r_ack ? w_next : r_adr;
   assign w_iss_ok  = (w_iss_adr >= C_LO) && (w_iss_adr < C_HI) && (w_iss_adr[1:0] == 2'b00);
   assign w_iss_off = w_iss_adr[31:0] - ADDR_BASE;
   assign w_iss_idx = w_iss_off[AW+1:2];
   assign w_cur_off = r_adr[31:0] - ADDR_BASE;
   assign w_cur_idx = w_cur_off[AW+1:2];
   assign w_wen     = (r_state == S_BEAT) && r_ack && r_we && wb_cyc_i && wb_stb_i;
   assign w_unused  = ^{wb_cab_i, w_iss_off[31:AW+2], w_iss_off[1:0],
                        w_cur_off[31:AW+2], w_cur_off[1:0]};

   // Write data is taken at the end of the ack cycle, when the master's beat data is valid.
   always_ff @(posedge clk) begin
      if (w_wen) begin
         for (int unsigned k = 0; k < 4; k++) begin
            if (wb_sel_i[k]) r_mem[w_cur_idx][8*k +: 8] <= wb_dat_i[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_wcnt  <= '0;
         r_adr   <= '0;
         r_bte   <= '0;
         r_burst <= 1'b0;
         r_we    <= 1'b0;
         r_retry <= 1'b0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_rty   <= 1'b0;
         r_dat   <= '0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         r_rty <= 1'b0;
         r_dat <= '0;
         case (r_state)
            S_IDLE: begin
               if (wb_cyc_i && wb_stb_i) begin
                  r_adr   <= {1'b0, wb_adr_i};
                  r_burst <= (wb_cti_i == 3'b010);
                  r_bte   <= wb_bte_i;
                  r_we    <= wb_we_i;
                  r_retry <= retry_req;
                  r_wcnt  <= '0;
                  r_state <= (WAIT_STATES > 0) ? S_WAIT : S_BEAT;
               end
            end
            S_WAIT: begin
               if (!wb_cyc_i)                             r_state <= S_IDLE;
               else if (r_wcnt == 4'(WAIT_STATES - 1))    r_state <= S_BEAT;
               else                                       r_wcnt  <= r_wcnt + 4'd1;
            end
            S_BEAT: begin
               if (!wb_cyc_i) begin
                  r_state <= S_IDLE;
               end else if (wb_stb_i) begin
                  // A pending ack completes here; either finish or issue the next beat.
                  if (r_ack && !w_advance) begin
                     r_state <= S_TERM;
                  end else begin
                     r_adr <= w_iss_adr;
                     if (r_retry) begin
                        r_rty   <= 1'b1;
                        r_state <= S_TERM;
                     end else if (!w_iss_ok) begin
                        r_err   <= 1'b1;
                        r_state <= S_TERM;
                     end else begin
                        r_ack <= 1'b1;
                        if (!r_we) r_dat <= r_mem[w_iss_idx];
                     end
                  end
               end
            end
            S_TERM: begin
               if (!wb_cyc_i || !wb_stb_i) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign wb_ack_o = r_ack;
   assign wb_err_o = r_err;
   assign wb_rty_o = r_rty;
   assign wb_dat_o = r_dat;

endmodule

// File: tb/tb_wb_ext_responder.sv
// Bench for wb_ext_responder: transaction-level memory/response model checked
// against the slave outputs every cycle, plus literal pins on key results.
module tb_wb_ext_responder;

   localparam logic [31:0] BASE  = 32'h1000_0000;
   localparam int unsigned WORDS = 16;
   localparam int unsigned WS    = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
   logic [3:0]  wb_sel_i;
   logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_cab_i, retry_req;
   logic [2:0]  wb_cti_i;
   logic [1:0]  wb_bte_i;
   logic        wb_ack_o, wb_err_o, wb_rty_o;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   bit          chk_en = 1'b0;
   logic        exp_ack = 1'b0, exp_err = 1'b0, exp_rty = 1'b0;
   logic [31:0] exp_dat = '0;
   logic [31:0] mem_m [WORDS];
   logic [31:0] bdat [16];
   int          lat;
   logic [31:0] last_rd;

   always #5 clk = ~clk;

   wb_ext_responder #(.ADDR_BASE(BASE), .MEM_WORDS(WORDS), .WAIT_STATES(WS)) u_dut (
      .clk(clk), .rst(rst),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_cab_i(wb_cab_i), .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
      .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
      .wb_dat_o(wb_dat_o), .retry_req(retry_req)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("ack", 32'(wb_ack_o), 32'(exp_ack));
         check("err", 32'(wb_err_o), 32'(exp_err));
         check("rty", 32'(wb_rty_o), 32'(exp_rty));
         check("dat", wb_dat_o, exp_dat);
      end
   end

   function automatic bit in_win(input logic [31:0] a);
      longint la, lb;
      la = longint'(a);
      lb = longint'(BASE);
      return (la >= lb) && (la < lb + longint'(4 * WORDS)) && (la % 4 == 0);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++) if (sel[k]) r[8*k +: 8] = d[8*k +: 8];
      return r;
   endfunction

   function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] bte, input int i);
      logic [31:0] span, blk;
      if (bte == 2'b00) return a + 32'(4 * i);
      span = (bte == 2'b01) ? 32'd16 : (bte == 2'b10) ? 32'd32 : 32'd64;
      blk  = a & ~(span - 32'd1);
      return blk + ((a - blk + 32'(4 * i)) % span);
   endfunction

   task automatic step(input logic a, input logic e, input logic r, input logic [31:0] d);
      @(posedge clk);
      #1;
      exp_ack = a; exp_err = e; exp_rty = r; exp_dat = d;
   endtask

   task automatic idle_bus();
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_sel_i = '0; wb_cti_i = '0;
      wb_bte_i = '0; wb_dat_i = '0; wb_adr_i = '0; retry_req = 0; wb_cab_i = 0;
   endtask

   task automatic classic(input bit we, input logic [31:0] adr, input logic [31:0] d,
                          input logic [3:0] sel, input bit rty, input logic [2:0] cti);
      bit ok, ea, ee, er;
      logic [31:0] rd;
      ok = in_win(adr);
      er = rty;
      ee = !rty && !ok;
      ea = !rty && ok;
      rd = (ea && !we) ? mem_m[widx(adr)] : 32'h0;
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = d;
      wb_sel_i = sel; wb_cti_i = cti; wb_bte_i = 2'b00; retry_req = rty;
      lat = -1;
      last_rd = '0;
      for (int j = 0; j <= int'(WS) + 1; j++) begin
         if (j == int'(WS) + 1) step(ea, ee, er, rd);
         else                   step(0, 0, 0, 32'h0);
         retry_req = 0;
         if (lat < 0 && (wb_ack_o || wb_err_o || wb_rty_o)) begin
            lat = j;
            last_rd = wb_dat_o;
         end
      end
      if (ea && we) mem_m[widx(adr)] = merge(mem_m[widx(adr)], d, sel);
      step(0, 0, 0, 32'h0);
      idle_bus();
      step(0, 0, 0, 32'h0);
   endtask

   task automatic burst(input bit we, input logic [31:0] adr, input logic [1:0] bte,
                        input int n, input logic [31:0] d0, input int rst_at);
      logic [31:0] a;
      bit ok;
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = d0;
      wb_sel_i = 4'hF; wb_cti_i = 3'b010; wb_bte_i = bte; retry_req = 0; wb_cab_i = 1;
      for (int j = 0; j <= int'(WS); j++) step(0, 0, 0, 32'h0);
      for (int i = 0; i < n; i++) begin
         a  = beat_addr(adr, bte, i);
         ok = in_win(a);
         step(ok, !ok, 0, (ok && !we) ? mem_m[widx(a)] : 32'h0);
         bdat[i]  = wb_dat_o;
         wb_dat_i = d0 + 32'(i);
         wb_cti_i = (i == n - 1) ? 3'b111 : 3'b010;
         if (i == rst_at) begin
            #2 rst = 0;
            exp_ack = 0; exp_err = 0; exp_rty = 0; exp_dat = '0;
            #1;
            check("rst_ack_now", 32'(wb_ack_o), 32'h0);
            check("rst_dat_now", wb_dat_o, 32'h0);
            idle_bus();
            step(0, 0, 0, 32'h0);
            rst = 1;
            break;
         end
         if (!ok) break;
         if (we) mem_m[widx(a)] = d0 + 32'(i);
      end
      step(0, 0, 0, 32'h0);
      idle_bus();
      step(0, 0, 0, 32'h0);
   endtask

   task automatic abort_wait(input logic [31:0] adr);
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = adr; wb_cti_i = 3'b000;
      step(0, 0, 0, 32'h0);
      idle_bus();
      step(0, 0, 0, 32'h0);
      step(0, 0, 0, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < int'(WORDS); i++) mem_m[i] = '0;
      idle_bus();
      rst = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1;
      check("reset_ack", 32'(wb_ack_o), 32'h0);
      check("reset_err", 32'(wb_err_o), 32'h0);
      check("reset_rty", 32'(wb_rty_o), 32'h0);
      check("reset_dat", wb_dat_o, 32'h0);
      rst = 1;

      for (int i = 0; i < 8; i++) classic(1, BASE + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 0, 3'b000);

      classic(1, BASE + 32'd8, 32'hDEAD_BEEF, 4'hF, 0, 3'b000);
      check("wr_latency", 32'(lat), 32'd3);
      classic(0, BASE + 32'd8, 32'h0, 4'hF, 0, 3'b111);
      check("rd_latency", 32'(lat), 32'd3);
      check("rd_deadbeef", last_rd, 32'hDEAD_BEEF);

      classic(1, BASE + 32'd20, 32'hFFFF_FFFF, 4'hF, 0, 3'b000);
      classic(1, BASE + 32'd20, 32'h1122_3344, 4'b0101, 0, 3'b001);
      classic(0, BASE + 32'd20, 32'h0, 4'hF, 0, 3'b101);
      check("sel_merge", last_rd, 32'hFF22_FF44);
      classic(1, BASE + 32'd20, 32'h0, 4'b0000, 0, 3'b000);
      check("sel0_acks", 32'(lat), 32'd3);
      classic(0, BASE + 32'd20, 32'h0, 4'hF, 0, 3'b000);
      check("sel0_nochg", last_rd, 32'hFF22_FF44);

      burst(0, BASE + 32'd8, 2'b01, 4, 32'h0, -1);
      check("wrap_b0", bdat[0], 32'hDEAD_BEEF);
      check("wrap_b1", bdat[1], 32'hA000_0003);
      check("wrap_b2", bdat[2], 32'hA000_0000);
      check("wrap_b3", bdat[3], 32'hA000_0001);

      classic(0, BASE + 32'(4 * WORDS), 32'h0, 4'hF, 0, 3'b000);
      check("oor_err_lat", 32'(lat), 32'd3);
      classic(0, BASE + 32'd2, 32'h0, 4'hF, 0, 3'b000);

      classic(0, BASE + 32'(4 * WORDS), 32'h0, 4'hF, 1, 3'b000);
      classic(1, BASE + 32'd16, 32'h5555_AAAA, 4'hF, 1, 3'b000);
      classic(0, BASE + 32'd16, 32'h0, 4'hF, 0, 3'b000);
      check("rty_nochg", last_rd, 32'hA000_0004);
      classic(0, BASE + 32'(4 * WORDS), 32'h0, 4'hF, 0, 3'b000);

      burst(1, BASE + 32'd56, 2'b00, 4, 32'hB000_0000, -1);
      classic(0, BASE + 32'd60, 32'h0, 4'hF, 0, 3'b000);
      check("lin_last_word", last_rd, 32'hB000_0001);

      abort_wait(BASE + 32'd4);
      classic(0, BASE + 32'd4, 32'h0, 4'hF, 0, 3'b000);
      check("after_abort", last_rd, 32'hA000_0001);

      burst(1, BASE, 2'b00, 8, 32'hC000_0000, 2);
      for (int i = 0; i < 8; i++) begin
         classic(0, BASE + 32'(4 * i), 32'h0, 4'hF, 0, 3'b000);
         if (i == 0) check("post_rst_lat", 32'(lat), 32'd3);
         if (i == 1) check("rst_word1", last_rd, 32'hC000_0001);
         if (i == 2) check("rst_word2", last_rd, 32'hDEAD_BEEF);
      end

      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
